ray_dir_gen: RTL

Sequential ray-direction generator sitting directly downstream of the quadrant sine lookup in the raycaster front end. On `start` it sweeps `NUM_RAYS` angles centred on the player heading. For each angle it performs two time-multiplexed lookups on one internal sine-table instance: sin(a), then cos(a) = sin(a + ROM_DEPTH). It emits one Q8.8 direction vector per ray over a valid/ready handshake to the DDA stepper.

---
 rtl/ray_dir_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ray_dir_gen.sv
// ray_dir_gen: sweeps NUM_RAYS angles around a heading and emits one Q8.8 (cos, sin) vector per ray.
// Optional feature macro RAY_DIR_SCALE_EN adds a `scale` input that multiplies both components with saturation.

module ray_dir_sine_lut #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int ADDRW     = $clog2(4*ROM_DEPTH)
) (
    input  logic [ADDRW-1:0]   addr,
    output logic signed [15:0] value
);
    localparam int OFFW = ADDRW - 2;
    localparam logic [15:0] UNITY = 16'd1 << ROM_WIDTH;

    // First-quadrant image round(256*sin(k*90/64 deg)), clamped to 255; identical to sine_table_64x8.mem.
    localparam logic [ROM_WIDTH-1:0] SINE_TABLE [ROM_DEPTH] = '{
        8'd0,   8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd38,  8'd44,
        8'd50,  8'd56,  8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,
        8'd98,  8'd104, 8'd109, 8'd115, 8'd121, 8'd126, 8'd132, 8'd137,
        8'd142, 8'd147, 8'd152, 8'd157, 8'd162, 8'd167, 8'd172, 8'd177,
        8'd181, 8'd185, 8'd190, 8'd194, 8'd198, 8'd202, 8'd206, 8'd209,
        8'd213, 8'd216, 8'd220, 8'd223, 8'd226, 8'd229, 8'd231, 8'd234,
        8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd250,
        8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255
    };

    logic [1:0]      quad_s;
    logic [OFFW-1:0] off_s;
    logic [OFFW-1:0] mirror_s;
    logic [15:0]     mag_s;

    // Quadrant fold: II/IV read the table mirrored (offset 0 there is exactly 1.0), III/IV negate.
    always_comb begin
        quad_s   = addr[ADDRW-1:ADDRW-2];
        off_s    = addr[OFFW-1:0];
        mirror_s = {OFFW{1'b0}} - off_s;
        mag_s    = 16'd0;
        if (quad_s[0]) begin
            if (off_s == {OFFW{1'b0}}) begin
                mag_s = UNITY;
            end else begin
                mag_s = {{(16-ROM_WIDTH){1'b0}}, SINE_TABLE[mirror_s]};
            end
        end else begin
            mag_s = {{(16-ROM_WIDTH){1'b0}}, SINE_TABLE[off_s]};
        end
        if (quad_s[1]) begin
            value = $signed(16'd0 - mag_s);
        end else begin
            value = $signed(mag_s);
        end
    end
endmodule

module ray_dir_gen #(
    parameter int ROM_DEPTH  = 64,
    parameter int ROM_WIDTH  = 8,
    parameter     ROM_FILE   = "sine_table_64x8.mem",
    parameter int ADDRW      = $clog2(4*ROM_DEPTH),
    parameter int NUM_RAYS   = 160,
    parameter int ANGLE_STEP = 1,
    parameter int RAYW       = $clog2(NUM_RAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDRW-1:0]    base_angle,
`ifdef RAY_DIR_SCALE_EN
    input  logic [15:0]         scale,
`endif
    input  logic                out_ready,
    output logic                busy,
    output logic                out_valid,
    output logic [RAYW-1:0]     ray_idx,
    output logic [ADDRW-1:0]    ray_angle,
    output logic signed [15:0]  dir_x,
    output logic signed [15:0]  dir_y,
    output logic                done
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SIN  = 2'd1,
        ST_COS  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [ADDRW-1:0] HALF_SPAN = ADDRW'((NUM_RAYS/2) * ANGLE_STEP);
    localparam logic [ADDRW-1:0] STEP_A    = ADDRW'(ANGLE_STEP);
    localparam logic [ADDRW-1:0] COS_OFF   = ADDRW'(ROM_DEPTH);
    localparam logic [RAYW-1:0]  LAST_IDX  = RAYW'(NUM_RAYS - 1);
    localparam logic [RAYW-1:0]  IDX_ONE   = RAYW'(1);

    state_t                 state_r;
    logic                   busy_r;
    logic                   out_valid_r;
    logic                   done_r;
    logic [RAYW-1:0]        ray_idx_r;
    logic [ADDRW-1:0]       ray_angle_r;
    logic signed [15:0]     sin_r;
    logic signed [15:0]     dir_x_r;
    logic signed [15:0]     dir_y_r;
    logic [ADDRW-1:0]       lut_addr_s;
    logic signed [15:0]     lut_s;

`ifdef RAY_DIR_SCALE_EN
    // Q8.8 product with a zero-extended multiplier, floored by the arithmetic shift, then clamped to int16.
    function automatic logic signed [15:0] scale_sat(input logic signed [15:0] v, input logic [15:0] s);
        logic signed [32:0] prod;
        logic signed [32:0] shr;
        prod = $signed({{17{v[15]}}, v}) * $signed({17'd0, s});
        shr  = prod >>> 8;
        if (shr > 33'sd32767) begin
            return 16'sh7FFF;
        end else if (shr < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return shr[15:0];
        end
    endfunction
`endif

    // One shared table: the COS state reads a quarter turn ahead of the ray angle.
    always_comb begin
        lut_addr_s = ray_angle_r;
        if (state_r == ST_COS) begin
            lut_addr_s = ray_angle_r + COS_OFF;
        end else begin
            lut_addr_s = ray_angle_r;
        end
    end

    ray_dir_sine_lut #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_WIDTH (ROM_WIDTH),
        .ADDRW     (ADDRW)
    ) u_sine_lut (
        .addr  (lut_addr_s),
        .value (lut_s)
    );

    // Sweep sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            ray_idx_r   <= {RAYW{1'b0}};
            ray_angle_r <= {ADDRW{1'b0}};
            sin_r       <= 16'sd0;
            dir_x_r     <= 16'sd0;
            dir_y_r     <= 16'sd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ray_idx_r   <= {RAYW{1'b0}};
                        ray_angle_r <= base_angle - HALF_SPAN;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SIN;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SIN: begin
                    sin_r   <= lut_s;
                    state_r <= ST_COS;
                end
                ST_COS: begin
`ifdef RAY_DIR_SCALE_EN
                    dir_x_r <= scale_sat(lut_s, scale);
                    dir_y_r <= scale_sat(sin_r, scale);
`else
                    dir_x_r <= lut_s;
                    dir_y_r <= sin_r;
`endif
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (ray_idx_r == LAST_IDX) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            ray_idx_r   <= ray_idx_r + IDX_ONE;
                            ray_angle_r <= ray_angle_r + STEP_A;
                            state_r     <= ST_SIN;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign ray_idx   = ray_idx_r;
    assign ray_angle = ray_angle_r;
    assign dir_x     = dir_x_r;
    assign dir_y     = dir_y_r;
endmodule
